// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for line_mem_responder: state encoding, line geometry and
// the enabled-byte search used by the LMR_SKIP_UNMASKED_EN build.
package lmr_defs;

   localparam int LMR_LINE_BYTES = 16;
   localparam int LMR_OFS_W      = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Lowest enabled byte index at or above 'from'; LMR_LINE_BYTES when none remain.
   function automatic logic [LMR_OFS_W:0] next_masked(
      input logic [LMR_LINE_BYTES-1:0] mask,
      input logic [LMR_OFS_W:0]        from
   );
      logic [LMR_OFS_W:0] idx;
      idx = (LMR_OFS_W+1)'(LMR_LINE_BYTES);
      for (int i = LMR_LINE_BYTES - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(from)))
            idx = (LMR_OFS_W+1)'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/line_mem_responder.sv
// Byte-serial cache-line responder: writes a masked line then/or reads a line
// through an 8-bit RAM port. Define LMR_SKIP_UNMASKED_EN to skip disabled bytes.
module line_mem_responder
   import lmr_defs::*;
#(
   parameter int LINE_BYTES = LMR_LINE_BYTES,
   parameter int ADDR_W     = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req_read,
   input  logic                    req_write,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [8*LINE_BYTES-1:0] req_data,
   input  logic [LINE_BYTES-1:0]   req_mask,
   output logic [8*LINE_BYTES-1:0] rsp_data,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic                    ram_wr,
   output logic [7:0]              ram_dout,
   input  logic [7:0]              ram_din
);

   localparam int               OFS_W    = LMR_OFS_W;
   localparam int               BASE_W   = ADDR_W - OFS_W;
   localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(LINE_BYTES - 1);

   logic [2:0]              state_q, state_d;
   logic [OFS_W-1:0]        cnt_q, cnt_d;
   logic [BASE_W-1:0]       base_q;
   logic [8*LINE_BYTES-1:0] data_q;
   logic [LINE_BYTES-1:0]   mask_q;
   logic                    rd_q;
   logic                    accept;
   logic                    wr_last;
   logic                    unused_addr_bits;

   assign accept           = (state_q == ST_IDLE) && (req_read || req_write);
   assign unused_addr_bits = ^req_addr[OFS_W-1:0];

`ifdef LMR_SKIP_UNMASKED_EN
   logic [OFS_W:0] first_wr;
   logic [OFS_W:0] next_wr;

   assign first_wr = next_masked(req_mask, '0);
   assign next_wr  = next_masked(mask_q, {1'b0, cnt_q} + 1'b1);
   assign wr_last  = next_wr[OFS_W];
`else
   assign wr_last  = (cnt_q == LAST_OFS);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req_write) begin
`ifdef LMR_SKIP_UNMASKED_EN
               if (first_wr[OFS_W]) begin
                  state_d = req_read ? ST_READ : ST_DONE;
               end else begin
                  state_d = ST_WRITE;
                  cnt_d   = first_wr[OFS_W-1:0];
               end
`else
               state_d = ST_WRITE;
`endif
            end else if (req_read) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (wr_last) begin
               state_d = rd_q ? ST_READ : ST_DONE;
               cnt_d   = '0;
            end else begin
`ifdef LMR_SKIP_UNMASKED_EN
               cnt_d = next_wr[OFS_W-1:0];
`else
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         ST_READ: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_OFS)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request fields are frozen at accept; inputs are ignored until back in IDLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            base_q <= req_addr[ADDR_W-1:OFS_W];
            data_q <= req_data;
            mask_q <= req_mask;
            rd_q   <= req_read;
         end
      end
   end

   // RAM data lags the address by one cycle, so byte gi lands while cnt_q = gi+1.
   generate
      for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_rsp
         logic       cap;
         logic [7:0] byte_q;

         assign cap = ((gi < LINE_BYTES - 1) && (state_q == ST_READ) &&
                       (cnt_q == OFS_W'(gi + 1)))
                   || ((gi == LINE_BYTES - 1) && (state_q == ST_DRAIN));

         always_ff @(posedge CLK) begin
            if (RST)
               byte_q <= '0;
            else if (cap)
               byte_q <= ram_din;
         end

         assign rsp_data[8*gi +: 8] = byte_q;
      end
   endgenerate

   always_comb begin
      ram_addr = '0;
      ram_wr   = 1'b0;
      ram_dout = '0;
      if ((state_q == ST_WRITE) || (state_q == ST_READ))
         ram_addr = {base_q, cnt_q};
      if (state_q == ST_WRITE) begin
         ram_wr   = mask_q[cnt_q];
         ram_dout = data_q[8*cnt_q +: 8];
      end
   end

   assign busy = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 The block SHALL have parameter LINE_BYTES, default 16, meaning the number of bytes per cache line transfer.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 The block SHALL use reset RST, synchronous, active-high, and clock CLK.
REQ-004 Ports SHALL be:
- CLK  in  1  clock.
- RST  in  1  sync reset, active-high.
- req_read  in  1  line read request, held until done.
- req_write  in  1  line write request, held until done.
- req_addr  in  ADDR_W  request address; low 4 bits ignored.
- req_data  in  128  write line; byte i = bits [8i+7:8i].
- req_mask  in  16  byte-enable; bit i enables byte i.
- rsp_data  out  128  read line result.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  byte address to RAM.
- ram_wr  out  1  RAM byte write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte, valid the cycle after ram_addr is presented with ram_wr=0.

Function
REQ-005 States SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-006 In IDLE, if req_read or req_write is 1 at a rising edge (accept edge A), the block SHALL latch base={req_addr[ADDR_W-1:4],4'b0}, req_data, req_mask, and the read/write flags; later changes to request inputs SHALL be ignored until DONE.
REQ-007 After an accept with req_write=1, the block SHALL enter WRITE; otherwise it SHALL enter READ.
REQ-008 In WRITE, byte i (0..15, ascending) SHALL drive ram_addr=base+i, ram_dout=byte i of latched data, and ram_wr=mask[i], one byte per cycle.
REQ-009 After the last WRITE byte, the block SHALL go to READ if the read flag is latched, else to DONE.
REQ-010 In READ, the block SHALL drive ram_addr=base+i with ram_wr=0 for i=0..15 on consecutive cycles and SHALL capture ram_din into rsp_data byte i-1 one cycle later.
REQ-011 DRAIN SHALL last one cycle, capture byte 15, and go to DONE.
REQ-012 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE; requests SHALL NOT be accepted in DONE.
REQ-013 busy SHALL be 1 in WRITE, READ and DRAIN, and 0 in IDLE and DONE.
REQ-014 Latency (macro undefined): read-only done at A+18; write-only done at A+17; write+read done at A+34.
REQ-015 Outside WRITE, ram_wr SHALL be 0; ram_addr and ram_dout SHALL be 0 in IDLE and DONE.
REQ-016 rsp_data SHALL change only during READ and DRAIN captures, and SHALL hold its value through write-only transactions and IDLE.
REQ-017 Address arithmetic base+i SHALL NOT carry out of the low 4 bits.
REQ-018 A write with req_mask=0 SHALL issue no RAM writes (ram_wr stays 0).

Reset
REQ-019 While RST=1, state SHALL be IDLE, and rsp_data, busy, done, ram_addr, ram_wr, and ram_dout SHALL be 0.
REQ-020 RST asserted mid-transaction SHALL abort the transaction at that edge: no further ram_wr, no done pulse, and partial rsp_data SHALL be cleared to 0.

Configuration
REQ-021 With LMR_SKIP_UNMASKED_EN defined, WRITE SHALL visit only bytes with mask[i]=1, one cycle each in ascending order. A mask of 0 SHALL skip WRITE entirely, and latency SHALL shrink by the number of unmasked bytes.
REQ-022 Without LMR_SKIP_UNMASKED_EN, WRITE SHALL always take exactly 16 cycles per REQ-008.

Structure
REQ-023 The shared package lmr_defs SHALL hold the state encoding, LINE_BYTES, and the offset width constant (4).
REQ-024 The block SHALL be a single module; no sub-module is required. The byte counter and state register SHALL be internal.

Verification
REQ-025 Read-only, base 0x1000, RAM byte k=k+0x10 -> rsp_data=0x1F1E..1110 (byte0=0x10), done exactly at A+18, busy=1 from A+1 to A+17.
REQ-026 Write-only, addr 0x2007, mask 0x00F0, data bytes 0..15=0xA0..0xAF -> RAM writes only at 0x2004..0x2007 with 0xA4..0xA7, done at A+17, rsp_data unchanged.
REQ-027 Write+read, same line, mask 0xFFFF -> the read returns exactly the written line, and done at A+34.
REQ-028 Write with mask 0 -> no ram_wr pulse. With the macro, done at A+1 (DONE entered directly); without it, done at A+17.
REQ-029 RST pulsed at A+8 of a write -> ram_wr stays 0 afterward, no done, outputs 0, and the next request is accepted normally.
REQ-030 Requests held high through DONE and dropped the cycle after -> exactly one transaction occurs, with no re-accept.
